// File: rtl/am_pkg.sv
// Alignment-marker constants, lock FSM states and BIP3 helper shared by the rx and tx sides.
package am_pkg;
  localparam int AM_PERIOD = 16384;
  localparam int CNT_W = 14;
  localparam logic [1:0] CTRL_HDR = 2'b10;

  // {M2,M1,M0} per lane with lane 0 in the low slot; M4..M6 carry the inverses.
  localparam logic [3:0][23:0] AM_M012 = {24'h3D79A2, 24'h9B65C5, 24'hE6C4F0, 24'h477690};

  typedef enum logic [1:0] {ST_FIND, ST_COUNT, ST_COMP, ST_LOCKED} am_state_t;

  // Payload bit k lands in parity bit (k+2) mod 8; sync header bits feed parity bits 3 and 4.
  function automatic logic [7:0] bip3(input logic [1:0] head, input logic [63:0] data);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) x = x ^ data[i*8 +: 8];
    return {x[5:0], x[7:6]} ^ {3'b000, head, 3'b000};
  endfunction
endpackage

// File: rtl/am_lane_lock.sv
// Per-lane alignment-marker lock FSM with block counter and mismatch count.
// With BIP_CHECK_EN defined, also accumulates BIP3 and flags parity errors at each marker.
module am_lane_lock #(
  parameter int HEAD_W    = 2,
  parameter int DATA_W    = 64,
  parameter int AM_PERIOD = am_pkg::AM_PERIOD,
  parameter int LANE_ID   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HEAD_W-1:0] head,
  input  logic [DATA_W-1:0] data,
  output logic              am_lock,
  output logic              at_marker
`ifdef BIP_CHECK_EN
  ,
  output logic              bip_err
`endif
);
  import am_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AM_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(AM_PERIOD - 2);
  localparam logic [23:0]      M012     = AM_M012[LANE_ID];

  am_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       miss, miss_nxt;
  logic             match;

  assign match     = (head == CTRL_HDR) && (data[23:0] == M012) && (data[55:32] == ~M012);
  assign am_lock   = (state == ST_LOCKED);
  assign at_marker = (state == ST_LOCKED) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FIND;
      cnt   <= '0;
      miss  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      miss  <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_nxt  = miss;
    unique case (state)
      ST_FIND: begin
        if (match) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = '0;
        end
      end
      // The block after CNT_END is the one where the second marker must appear.
      ST_COUNT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_END) state_nxt = ST_COMP;
      end
      ST_COMP: begin
        if (match) begin
          state_nxt = ST_LOCKED;
          cnt_nxt   = '0;
          miss_nxt  = '0;
        end else begin
          state_nxt = ST_FIND;
        end
      end
      ST_LOCKED: begin
        cnt_nxt = at_marker ? '0 : cnt + 1'b1;
        if (at_marker) begin
          if (match) begin
            miss_nxt = '0;
          end else if (miss == 2'd3) begin
            state_nxt = ST_FIND;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss + 1'b1;
          end
        end
      end
      default: state_nxt = ST_FIND;
    endcase
  end

`ifdef BIP_CHECK_EN
  logic [7:0] acc;
  logic       restart;

  // Parity restarts on whichever block the FSM treats as a marker.
  assign restart = ((state == ST_FIND || state == ST_COMP) && match) || at_marker;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      bip_err <= 1'b0;
    end else begin
      bip_err <= at_marker && (acc != data[31:24]);
      acc     <= restart ? bip3(head, data) : (acc ^ bip3(head, data));
    end
  end
`else
  logic unused_bytes;
  assign unused_bytes = ^{data[63:56], data[31:24]};
`endif
endmodule

// File: rtl/alignement_marker_rx.sv
// Multi-lane alignment-marker receiver: 1-cycle data pass-through, per-lane lock, marker flag.
// Optional BIP3 checking via BIP_CHECK_EN adds bip_err_o.
module alignement_marker_rx #(
  parameter int LANE_N    = 4,
  parameter int HEAD_W    = 2,
  parameter int DATA_W    = 64,
  parameter int AM_PERIOD = am_pkg::AM_PERIOD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic [LANE_N*HEAD_W-1:0] head_o,
  output logic [LANE_N*DATA_W-1:0] data_o,
  output logic                     marker_v_o,
  output logic [LANE_N-1:0]        am_lock_o,
  output logic                     all_lock_o
`ifdef BIP_CHECK_EN
  ,
  output logic [LANE_N-1:0]        bip_err_o
`endif
);
  logic [LANE_N-1:0] at_marker;
  logic              marker_q;
  logic              unused_at_marker;

  for (genvar n = 0; n < LANE_N; n++) begin : g_lane
    am_lane_lock #(
      .HEAD_W    (HEAD_W),
      .DATA_W    (DATA_W),
      .AM_PERIOD (AM_PERIOD),
      .LANE_ID   (n)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .head      (head_i[n*HEAD_W +: HEAD_W]),
      .data      (data_i[n*DATA_W +: DATA_W]),
      .am_lock   (am_lock_o[n]),
      .at_marker (at_marker[n])
`ifdef BIP_CHECK_EN
      ,
      .bip_err   (bip_err_o[n])
`endif
    );
  end

  assign all_lock_o       = &am_lock_o;
  assign unused_at_marker = ^at_marker[LANE_N-1:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_o   <= '0;
      data_o   <= '0;
      marker_q <= 1'b0;
    end else begin
      head_o   <= head_i;
      data_o   <= data_i;
      marker_q <= all_lock_o & at_marker[0];
    end
  end

  // Masking with the live lock keeps the flag low on the block where lock is lost.
  assign marker_v_o = marker_q & all_lock_o;
endmodule

// File: tb/tb_alignement_marker_rx.sv
// Directed bench for alignement_marker_rx with a short marker period; BIP checks need BIP_CHECK_EN.
module tb_alignement_marker_rx;
  localparam int P = 16;
  localparam logic [23:0] M012 [4] = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   head_i, head_o;
  logic [255:0] data_i, data_o;
  logic         marker_v_o, all_lock_o;
  logic [3:0]   am_lock_o;
`ifdef BIP_CHECK_EN
  logic [3:0]   bip_err_o;
`endif

  int checks = 0;
  int failures = 0;
  int ph = 0;
  logic [3:0]   drop_mk, bad_m1;
  logic         inject_l0, flip_l3;
  logic [7:0]   bip_acc [4];
  logic [7:0]   last_head;
  logic [255:0] last_data;
  int           mv, mv_tot;
  logic         mv0;

  always #5 clk = ~clk;

  alignement_marker_rx #(.AM_PERIOD(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .head_i     (head_i),
    .data_i     (data_i),
    .head_o     (head_o),
    .data_o     (data_o),
    .marker_v_o (marker_v_o),
    .am_lock_o  (am_lock_o),
    .all_lock_o (all_lock_o)
`ifdef BIP_CHECK_EN
    ,
    .bip_err_o  (bip_err_o)
`endif
  );

  function automatic logic [7:0] blk_bip(input logic [1:0] h, input logic [63:0] d);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 64; k++) b[(k + 2) % 8] = b[(k + 2) % 8] ^ d[k];
    b[3] = b[3] ^ h[0];
    b[4] = b[4] ^ h[1];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One block per lane; markers at phase 0 carry the running BIP3 in M3.
  task automatic cyc();
    logic [1:0]  h;
    logic [63:0] d;
    for (int n = 0; n < 4; n++) begin
      h = 2'b01;
      d = {$urandom, $urandom};
      if (ph == 0 && !drop_mk[n]) begin
        h = 2'b10;
        d = {8'hC3, ~M012[n], bip_acc[n], M012[n]};
        if (bad_m1[n]) d[15:8] = 8'h00;
      end else if (ph == 5 && inject_l0 && n == 0) begin
        h = 2'b10;
        d = {8'h5A, ~M012[0], 8'h33, M012[0]};
      end
      bip_acc[n] = (ph == 0) ? blk_bip(h, d) : (bip_acc[n] ^ blk_bip(h, d));
      if (ph == 9 && flip_l3 && n == 3) d[17] = ~d[17];
      head_i[n*2 +: 2]  = h;
      data_i[n*64 +: 64] = d;
    end
    last_head = head_i;
    last_data = data_i;
    @(posedge clk);
    #1;
    ph = (ph + 1) % P;
  endtask

  task automatic period(output int cnt, output logic first);
    cnt = 0;
    first = 1'b0;
    for (int i = 0; i < P; i++) begin
      cyc();
      if (i == 0) first = marker_v_o;
      if (marker_v_o) cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    head_i = '1;
    data_i = '1;
    drop_mk = '0;
    bad_m1 = '0;
    inject_l0 = 1'b0;
    flip_l3 = 1'b0;
    for (int n = 0; n < 4; n++) bip_acc[n] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_head", head_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_lock", am_lock_o, 0);
    chk("rst_all", all_lock_o, 0);
    chk("rst_mv", marker_v_o, 0);
    @(negedge clk) reset = 1'b0;

    // First marker, then lock on the second one a period later.
    cyc();
    chk("lat_head", head_o, last_head);
    chk("lat_data", data_o, last_data);
    chk("lock_first", am_lock_o, 0);
    while (ph != 0) cyc();
    chk("lock_early", am_lock_o, 0);
    cyc();
    chk("lock_acq", am_lock_o, 4'hF);
    chk("all_acq", all_lock_o, 1);
    cyc();
    chk("mv_nonmk", marker_v_o, 0);
    while (ph != 0) cyc();
    period(mv, mv0);
    chk("mv_at_mk", mv0, 1);
    chk("mv_count", mv, 1);

    // Lane 0 marker pattern at a non-marker position.
    inject_l0 = 1'b1;
    period(mv, mv0);
    inject_l0 = 1'b0;
    chk("inj_mv", mv, 1);
    chk("inj_lock", am_lock_o, 4'hF);

    // Lane 2 M1 corrupted for 3 periods, restored, then again for 3.
    mv_tot = 0;
    bad_m1[2] = 1'b1;
    repeat (3) begin period(mv, mv0); mv_tot += mv; end
    chk("bad3_lock", am_lock_o, 4'hF);
    bad_m1[2] = 1'b0;
    period(mv, mv0); mv_tot += mv;
    bad_m1[2] = 1'b1;
    repeat (3) begin period(mv, mv0); mv_tot += mv; end
    bad_m1[2] = 1'b0;
    chk("bad_mv", mv_tot, 7);
    chk("bad_lock", am_lock_o, 4'hF);

    // Lane 1 markers removed for 4 periods.
    drop_mk[1] = 1'b1;
    mv_tot = 0;
    repeat (3) begin period(mv, mv0); mv_tot += mv; end
    chk("drop3_mv", mv_tot, 3);
    chk("drop3_lock", am_lock_o, 4'hF);
    period(mv, mv0);
    chk("drop4_mv", mv, 0);
    chk("drop4_lock", am_lock_o, 4'hD);
    chk("drop4_all", all_lock_o, 0);
    drop_mk[1] = 1'b0;
    period(mv, mv0);
    chk("regain1_mv", mv, 0);
    chk("regain1_lock", am_lock_o, 4'hD);
    period(mv, mv0);
    chk("regain2_lock", am_lock_o, 4'hF);
    period(mv, mv0);
    chk("regain_mv", mv, 1);

    // Asynchronous reset in the middle of a period.
    while (ph != 7) cyc();
    #2 reset = 1'b1;
    #1;
    chk("arst_lock", am_lock_o, 0);
    chk("arst_all", all_lock_o, 0);
    chk("arst_mv", marker_v_o, 0);
    chk("arst_data", data_o, 0);
    cyc();
    cyc();
    reset = 1'b0;
    while (ph != 0) cyc();
    cyc();
    chk("relock1", am_lock_o, 0);
    while (ph != 0) cyc();
    cyc();
    chk("relock2", am_lock_o, 4'hF);
    while (ph != 0) cyc();
    period(mv, mv0);
    chk("relock_mv", mv, 1);

`ifdef BIP_CHECK_EN
    chk("bip_clean", bip_err_o, 0);
    flip_l3 = 1'b1;
    period(mv, mv0);
    flip_l3 = 1'b0;
    cyc();
    chk("bip_err", bip_err_o, 4'b1000);
    chk("bip_mv", marker_v_o, 1);
    cyc();
    chk("bip_pulse", bip_err_o, 0);
    while (ph != 0) cyc();
    cyc();
    chk("bip_next", bip_err_o, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
